// File: rtl/mul_seq_ctrl.sv
// Sequential multiply controller: forms a*b by repeated addition, driving an
// external combinational ALU one operation per cycle behind a start/done handshake.
module mul_seq_ctrl #(
    parameter int         N       = 4,
    parameter logic [3:0] OP_ADD  = 4'b0000,
    parameter logic [3:0] OP_SUB  = 4'b0001,
    parameter logic [3:0] OP_IDLE = 4'b0111
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] a_in,
    input  logic [N-1:0] b_in,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] product,
    output logic         ovf,
    output logic         err,
    output logic [N-1:0] alu_a,
    output logic [N-1:0] alu_b,
    output logic [3:0]   alu_op,
    input  logic [N-1:0] alu_out,
    input  logic         alu_of,
    input  logic         alu_un,
    input  logic         alu_err,
    input  logic         alu_zero
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ACC  = 2'd1;
    localparam logic [1:0] S_DEC  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]   state;
    logic [N-1:0] acc;
    logic [N-1:0] cnt;
    logic [N-1:0] mcand;

    // The decrement starts from cnt >= 1, so a borrow is impossible there.
    logic unused_alu_un;
    assign unused_alu_un = alu_un;

    always_comb begin
        alu_a  = '0;
        alu_b  = '0;
        alu_op = OP_IDLE;
        case (state)
            S_ACC: begin
                alu_a  = acc;
                alu_b  = mcand;
                alu_op = OP_ADD;
            end
            S_DEC: begin
                alu_a  = cnt;
                alu_b  = N'(1);
                alu_op = OP_SUB;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            acc     <= '0;
            cnt     <= '0;
            mcand   <= '0;
            product <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            ovf     <= 1'b0;
            err     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        mcand <= a_in;
                        cnt   <= b_in;
                        acc   <= '0;
                        ovf   <= 1'b0;
                        err   <= 1'b0;
                        busy  <= 1'b1;
                        if (b_in == '0) begin
                            // acc is being cleared on this same edge, so publish zero directly
                            product <= '0;
                            done    <= 1'b1;
                            state   <= S_DONE;
                        end else begin
                            state <= S_ACC;
                        end
                    end
                end
                S_ACC: begin
                    if (alu_err) begin
                        err     <= 1'b1;
                        product <= acc;
                        done    <= 1'b1;
                        state   <= S_DONE;
                    end else begin
                        acc   <= alu_out;
                        ovf   <= ovf | alu_of;
                        state <= S_DEC;
                    end
                end
                S_DEC: begin
                    if (alu_err) begin
                        err     <= 1'b1;
                        product <= acc;
                        done    <= 1'b1;
                        state   <= S_DONE;
                    end else begin
                        cnt <= alu_out;
                        if (alu_zero) begin
                            product <= acc;
                            done    <= 1'b1;
                            state   <= S_DONE;
                        end else begin
                            state <= S_ACC;
                        end
                    end
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/mul_seq_ctrl.md
Name: mul_seq_ctrl

Overview:
Sequential multiply controller sitting directly upstream of the combinational ALU (aluOp). It computes product = a × b by repeated addition. Each cycle it drives the ALU's a/b/op inputs and consumes the ALU's out/of/un/err/zero results. It replaces the bench-driven while-loop with a synthesizable FSM and a start/done handshake.

Parameters:
N, 4, operand/result width; must match the ALU width parameter.
OP_ADD, 4'b0000, ALU opcode computing alu_a + alu_b.
OP_SUB, 4'b0001, ALU opcode computing alu_a - alu_b.
OP_IDLE, 4'b0111, opcode driven when no ALU operation is issued.

Ports:
clk  input  1  single clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  request; sampled only in IDLE
a_in  input  N  multiplicand, latched on accepted start
b_in  input  N  multiplier (repeat count), latched on accepted start
busy  output  1  high from the cycle after an accepted start until DONE is left
done  output  1  one-cycle pulse; product/ovf/err valid
product  output  N  result, modulo 2^N; held until next accepted start
ovf  output  1  sticky; set if any ADD reported alu_of
err  output  1  set if the ALU reported alu_err; operation aborted
alu_a  output  N  ALU operand A
alu_b  output  N  ALU operand B
alu_op  output  4  ALU opcode
alu_out  input  N  ALU result (combinational, same cycle)
alu_of  input  1  ALU overflow flag
alu_un  input  1  ALU underflow flag
alu_err  input  1  ALU error flag
alu_zero  input  1  ALU zero flag (alu_out == 0)

Behaviour:
- Reset (async, rst=1): state=IDLE; acc, cnt, mcand, product=0; busy=done=ovf=err=0; alu_a=alu_b=0, alu_op=OP_IDLE. Reset mid-operation discards all work immediately; no done pulse.
- Internal regs: mcand (N), cnt (N), acc (N).
- IDLE: ALU driven with OP_IDLE, 0, 0. On start=1: mcand<=a_in, cnt<=b_in, acc<=0, ovf<=0, err<=0.
  - If b_in==0 (internal compare), go to DONE.
  - Otherwise go to ACC.
- ACC: alu_a=acc, alu_b=mcand, alu_op=OP_ADD. On the clock edge: acc<=alu_out; ovf<=ovf|alu_of. Next state DEC.
- DEC: alu_a=cnt, alu_b=1, alu_op=OP_SUB. On the clock edge: cnt<=alu_out. If alu_zero=1 go to DONE, else go to ACC.
- Error handling: if alu_err=1 in ACC or DEC, set err, do not update acc/cnt, and go to DONE. product then holds the acc value before the failing op.
- alu_un in DEC is ignored: cnt≥1 there, so it cannot legitimately underflow.
- DONE: product<=acc (registered on entry, visible while done=1); done=1 for exactly one cycle; busy=1; ALU driven with OP_IDLE. Next state IDLE unconditionally.
- busy=1 in ACC, DEC and DONE; busy=0 in IDLE.
- start while busy=1 is ignored, with no queuing. start in the same cycle the FSM returns to IDLE is accepted on the following edge (IDLE samples it).
- Latency: start accepted at edge E0.
  - b=0: done high in the cycle after E0.
  - b=k>0: k ADD + k SUB cycles, then done high in cycle 2k+1 after E0.
- Arithmetic: all adds wrap mod 2^N. ovf reports any wrap; product is the low N bits of a×b.
- Outputs are registered except alu_a/alu_b/alu_op, which are combinational decodes of state and regs.

Test Plan:
- Basic: a=4, b=3, pulse start → done pulses 7 cycles after accept; product=12, ovf=0, err=0; alu_op sequence ADD,SUB,ADD,SUB,ADD,SUB.
- Overflow: a=5, b=4 → product=4 (20 mod 16), ovf=1, done after 9 cycles.
- Zero multiplier: a=9, b=0 → done next cycle, product=0, no ALU ADD issued (alu_op stays OP_IDLE).
- Long run: a=0, b=15 → product=0, ovf=0, done 31 cycles after accept, busy high throughout.
- Robustness: start re-pulsed with a=7, b=7 while busy during a=2, b=3 → ignored, product=6. Then rst asserted mid-op of a=3, b=5 → all outputs 0 immediately; next start a=3, b=5 → product=15.
- Error path: ALU model forces alu_err=1 on the second ADD of a=2, b=4 → err=1, product=2, done pulses, FSM returns to IDLE.
